// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the byte-serial RAM/IO bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } arb_state_e;

  localparam logic [1:0] MASK_B = 2'b01;
  localparam logic [1:0] MASK_H = 2'b10;
  localparam logic [1:0] MASK_W = 2'b11;

  localparam logic [31:0] IO_ADDR_DEFAULT = 32'h0003_0000;

  // Byte count for a load/store mask; the unused encoding maps to 0.
  function automatic logic [2:0] mask_to_len(input logic [1:0] mask);
    logic [2:0] len;
    case (mask)
      MASK_B:  len = 3'd1;
      MASK_H:  len = 3'd2;
      MASK_W:  len = 3'd4;
      default: len = 3'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/mem_byte_asm.sv
// Four-lane read assembly register: clear, single-lane byte write, and an output that zeroes
// every lane at or above the transfer length.
module mem_byte_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        we,
  input  logic [1:0]  lane,
  input  logic [7:0]  din,
  input  logic [2:0]  len,
  output logic [31:0] dout
);

  logic [31:0] bytes_q, bytes_d;

  always_comb begin
    bytes_d = bytes_q;
    if (clr) begin
      bytes_d = '0;
    end else if (we) begin
      bytes_d[{lane, 3'b000} +: 8] = din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bytes_q <= '0;
    end else begin
      bytes_q <= bytes_d;
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < len) begin
        dout[8*i +: 8] = bytes_q[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single byte-wide RAM/IO bus between instruction fetch and load/store, splitting
// each request into per-byte bus cycles and reassembling read data.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(IO_ADDR_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy_in,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_mask,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  arb_state_e        state_q, state_d;
  logic              op_if_q, op_if_d;
  logic              op_we_q, op_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        issue_q, issue_d;
  logic [2:0]        cap_q, cap_d;
  logic              stall_q, stall_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic              mem_valid;
  logic              asm_clr, asm_we;
  logic [31:0]       asm_dout;
  logic [ADDR_W-1:0] issue_addr, replay_addr;
  logic [7:0]        issue_byte;

  assign mem_valid   = mem_req && (mem_mask != 2'b00);
  assign issue_addr  = addr_q + ADDR_W'(issue_q);
  assign replay_addr = addr_q + ADDR_W'(cap_q);
  assign issue_byte  = wdata_q[{issue_q[1:0], 3'b000} +: 8];

  mem_byte_asm u_asm (
    .clk  (clk),
    .rst  (rst),
    .clr  (asm_clr),
    .we   (asm_we),
    .lane (cap_q[1:0]),
    .din  (ram_din),
    .len  (len_q),
    .dout (asm_dout)
  );

  always_comb begin
    state_d     = state_q;
    op_if_d     = op_if_q;
    op_we_d     = op_we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    len_d       = len_q;
    issue_d     = issue_q;
    cap_d       = cap_q;
    stall_d     = stall_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = ram_wr_q;
    if_done_d   = if_done_q;
    mem_done_d  = mem_done_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    asm_clr     = 1'b0;
    asm_we      = 1'b0;

    if (!rdy_in) begin
      // Bus data seen across a stall is untrustworthy; remember to re-present the address.
      if (state_q == StRead) begin
        stall_d = 1'b1;
      end
    end else begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mem_valid || if_req) begin
            op_if_d = !mem_valid;
            op_we_d = mem_valid && mem_we;
            addr_d  = mem_valid ? mem_addr : if_addr;
            wdata_d = mem_wdata;
            if (!mem_valid) begin
              len_d = 3'd4;
            end else if (!mem_we && (mem_addr == IO_ADDR)) begin
              len_d = 3'd1;
            end else begin
              len_d = mask_to_len(mem_mask);
            end
            issue_d    = 3'd1;
            cap_d      = 3'd0;
            stall_d    = 1'b0;
            ram_a_d    = addr_d;
            ram_dout_d = op_we_d ? mem_wdata[7:0] : 8'h00;
            ram_wr_d   = op_we_d;
            asm_clr    = 1'b1;
            state_d    = op_we_d ? StWrite : StRead;
          end
        end

        StRead: begin
          if (op_if_q && if_flush) begin
            stall_d = 1'b0;
            state_d = StIdle;
          end else if (cap_q == len_q) begin
            stall_d = 1'b0;
            state_d = StDone;
            if (op_if_q) begin
              if_done_d = 1'b1;
              if_data_d = asm_dout;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = asm_dout;
            end
          end else if (stall_q) begin
            stall_d = 1'b0;
            ram_a_d = replay_addr;
            issue_d = cap_q + 3'd1;
          end else begin
            if (cap_q < issue_q) begin
              asm_we = 1'b1;
              cap_d  = cap_q + 3'd1;
            end
            if (issue_q < len_q) begin
              ram_a_d = issue_addr;
              issue_d = issue_q + 3'd1;
            end
          end
        end

        StWrite: begin
          if (issue_q == len_q) begin
            ram_wr_d   = 1'b0;
            mem_done_d = 1'b1;
            state_d    = StDone;
          end else begin
            ram_a_d    = issue_addr;
            ram_dout_d = issue_byte;
            ram_wr_d   = 1'b1;
            issue_d    = issue_q + 3'd1;
          end
        end

        StDone: begin
          state_d = StIdle;
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      op_if_q     <= 1'b0;
      op_we_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      len_q       <= '0;
      issue_q     <= '0;
      cap_q       <= '0;
      stall_q     <= 1'b0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_if_q     <= op_if_d;
      op_we_q     <= op_we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      len_q       <= len_d;
      issue_q     <= issue_d;
      cap_q       <= cap_d;
      stall_q     <= stall_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q & rdy_in;
  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of loads/stores plus hand-written sequences
// for arbitration, stall replay, fetch flush and reset during a store.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy_in;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_mask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .rdy_in    (rdy_in),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_done   (if_done),
    .if_data   (if_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_mask  (mem_mask),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .ram_a     (ram_a),
    .ram_dout  (ram_dout),
    .ram_wr    (ram_wr),
    .ram_din   (ram_din)
  );

  // RAM model: preloaded contents overlaid by anything the DUT writes.
  bit          written [0:8191];
  logic [7:0]  wram    [0:8191];
  logic [31:0] wr_a    [0:63];
  logic [7:0]  wr_d    [0:63];
  int          wr_total;
  bit          rdy_d1;
  logic [7:0]  mem_val;

  function automatic logic [7:0] preload(input logic [31:0] a);
    case (a)
      32'h100:   return 8'h13;
      32'h101:   return 8'h00;
      32'h102:   return 8'h50;
      32'h103:   return 8'h00;
      32'h200:   return 8'h11;
      32'h201:   return 8'h22;
      32'h202:   return 8'h33;
      32'h203:   return 8'h44;
      32'h1000:  return 8'hEF;
      32'h1001:  return 8'hBE;
      32'h1002:  return 8'hAD;
      32'h1003:  return 8'hDE;
      32'h30000: return 8'h41;
      default:   return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    rdy_d1 <= rdy_in;
    if (ram_wr) begin
      wr_a[wr_total % 64] <= ram_a;
      wr_d[wr_total % 64] <= ram_dout;
      wr_total <= wr_total + 1;
      if (ram_a < 32'd8192) begin
        written[ram_a[12:0]] <= 1'b1;
        wram[ram_a[12:0]]    <= ram_dout;
      end
    end
  end

  always_comb begin
    if (ram_a < 32'd8192 && written[ram_a[12:0]]) mem_val = wram[ram_a[12:0]];
    else mem_val = preload(ram_a);
  end

  // Data only follows the address once the bus has run a full cycle since any stall.
  assign ram_din = (rdy_in && rdy_d1) ? mem_val : 8'hFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Caller is just past a negedge in an idle cycle; k counts the negedge after edge Ek.
  task automatic run_mem(input logic we, input logic [1:0] mask, input logic [31:0] addr,
                         input logic [31:0] wdata, output int cyc, output logic [31:0] rd);
    mem_req = 1'b1; mem_we = we; mem_mask = mask; mem_addr = addr; mem_wdata = wdata;
    cyc = -1; rd = '0;
    for (int k = 0; k <= 20 && cyc < 0; k++) begin
      @(negedge clk);
      if (mem_done) begin cyc = k; rd = mem_rdata; end
    end
    mem_req = 1'b0; mem_mask = 2'b00;
    @(negedge clk);
    check("mem_done_one_cycle", {31'b0, mem_done}, 32'h0);
  endtask

  task automatic run_if(input logic [31:0] addr, output int cyc, output logic [31:0] rd);
    if_req = 1'b1; if_addr = addr;
    cyc = -1; rd = '0;
    for (int k = 0; k <= 20 && cyc < 0; k++) begin
      @(negedge clk);
      if (if_done) begin cyc = k; rd = if_data; end
    end
    if_req = 1'b0;
    @(negedge clk);
    check("if_done_one_cycle", {31'b0, if_done}, 32'h0);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
    logic [31:0] rdata;
    int          nwr;
  } vec_t;

  initial begin
    vec_t        vecs [0:8];
    int          cyc, cyc2, w0, cnt;
    logic [31:0] rd, rd2;

    vecs[0] = '{1'b1, 2'b10, 32'h20,    32'h0000BEEF, 2, 32'h0,        2};
    vecs[1] = '{1'b1, 2'b01, 32'h21,    32'h0000005A, 1, 32'h0,        1};
    vecs[2] = '{1'b0, 2'b10, 32'h20,    32'h0,        3, 32'h00005AEF, 0};
    vecs[3] = '{1'b1, 2'b11, 32'h40,    32'h0A0B0C0D, 4, 32'h0,        4};
    vecs[4] = '{1'b0, 2'b11, 32'h40,    32'h0,        5, 32'h0A0B0C0D, 0};
    vecs[5] = '{1'b0, 2'b11, 32'h200,   32'h0,        5, 32'h44332211, 0};
    vecs[6] = '{1'b0, 2'b10, 32'h202,   32'h0,        3, 32'h00004433, 0};
    vecs[7] = '{1'b0, 2'b01, 32'h203,   32'h0,        2, 32'h00000044, 0};
    vecs[8] = '{1'b0, 2'b11, 32'h30000, 32'h0,        2, 32'h00000041, 0};

    rst = 1'b0; rdy_in = 1'b1;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_mask = 2'b00; mem_addr = '0; mem_wdata = '0;
    repeat (2) @(negedge clk);
    check("reset_ram_a", ram_a, 32'h0);
    check("reset_ram_wr", {31'b0, ram_wr}, 32'h0);
    check("reset_ram_dout", {24'b0, ram_dout}, 32'h0);
    check("reset_if_done", {31'b0, if_done}, 32'h0);
    check("reset_mem_done", {31'b0, mem_done}, 32'h0);
    check("reset_if_data", if_data, 32'h0);
    check("reset_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Word fetch
    w0 = wr_total;
    run_if(32'h100, cyc, rd);
    check("if_fetch_latency", cyc, 5);
    check("if_fetch_data", rd, 32'h00500013);
    check("if_fetch_no_wr", wr_total - w0, 0);

    // Load/store table
    for (int i = 0; i < 9; i++) begin
      w0 = wr_total;
      run_mem(vecs[i].we, vecs[i].mask, vecs[i].addr, vecs[i].wdata, cyc, rd);
      check($sformatf("vec%0d_latency", i), cyc, vecs[i].cyc);
      if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      check($sformatf("vec%0d_nwr", i), wr_total - w0, vecs[i].nwr);
      for (int j = 0; j < vecs[i].nwr; j++) begin
        check($sformatf("vec%0d_wr%0d_addr", i, j), wr_a[(w0 + j) % 64], vecs[i].addr + j);
        check($sformatf("vec%0d_wr%0d_data", i, j), {24'b0, wr_d[(w0 + j) % 64]},
              {24'b0, vecs[i].wdata[8*j +: 8]});
      end
    end

    // mask 00 is not a request
    mem_req = 1'b1; mem_we = 1'b0; mem_mask = 2'b00; mem_addr = 32'h200;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_done || if_done) cnt++;
    end
    check("mask00_no_done", cnt, 0);
    check("mask00_ram_a_idle", ram_a, 32'h30000);
    mem_req = 1'b0;
    @(negedge clk);

    // Simultaneous requests: MEM first, IF after DONE + IDLE
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_mask = 2'b11; mem_addr = 32'h1000;
    cyc = -1; cyc2 = -1; rd = '0; rd2 = '0;
    for (int k = 0; k <= 30 && cyc2 < 0; k++) begin
      @(negedge clk);
      if (mem_done) begin cyc = k; rd = mem_rdata; mem_req = 1'b0; mem_mask = 2'b00; end
      if (if_done) begin cyc2 = k; rd2 = if_data; if_req = 1'b0; end
    end
    mem_req = 1'b0; if_req = 1'b0;
    check("arb_mem_latency", cyc, 5);
    check("arb_mem_rdata", rd, 32'hDEADBEEF);
    check("arb_if_latency", cyc2, 12);
    check("arb_if_data", rd2, 32'h00500013);
    @(negedge clk);

    // Stall after byte 1 is captured during a word read
    w0 = wr_total;
    mem_req = 1'b1; mem_we = 1'b0; mem_mask = 2'b11; mem_addr = 32'h200;
    repeat (3) @(negedge clk);
    check("stall_ram_a_before", ram_a, 32'h202);
    rdy_in = 1'b0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_done || ram_wr) cnt++;
    end
    check("stall_quiet", cnt, 0);
    check("stall_ram_a_held", ram_a, 32'h202);
    rdy_in = 1'b1;
    cyc = -1; rd = '0;
    for (int k = 6; k <= 25 && cyc < 0; k++) begin
      @(negedge clk);
      if (k == 6) check("stall_replay_ram_a", ram_a, 32'h202);
      if (mem_done) begin cyc = k; rd = mem_rdata; end
    end
    mem_req = 1'b0; mem_mask = 2'b00;
    check("stall_latency", cyc, 9);
    check("stall_rdata", rd, 32'h44332211);
    check("stall_no_wr", wr_total - w0, 0);
    @(negedge clk);

    // Flush sampled at E2 of a fetch, new fetch held straight after
    if_req = 1'b1; if_addr = 32'h100;
    repeat (2) @(negedge clk);
    if_flush = 1'b1; if_addr = 32'h200;
    @(negedge clk);
    check("flush_no_done", {31'b0, if_done}, 32'h0);
    if_flush = 1'b0;
    @(negedge clk);
    check("flush_refetch_ram_a", ram_a, 32'h200);
    cyc = -1; rd = '0;
    for (int k = 4; k <= 25 && cyc < 0; k++) begin
      @(negedge clk);
      if (if_done) begin cyc = k; rd = if_data; end
    end
    if_req = 1'b0;
    check("flush_refetch_latency", cyc, 8);
    check("flush_refetch_data", rd, 32'h44332211);
    @(negedge clk);

    // Reset in the middle of a word store
    mem_req = 1'b1; mem_we = 1'b1; mem_mask = 2'b11; mem_addr = 32'h60; mem_wdata = 32'h11223344;
    @(negedge clk);
    check("rst_store_wr0", {31'b0, ram_wr}, 32'h1);
    check("rst_store_a0", ram_a, 32'h60);
    check("rst_store_d0", {24'b0, ram_dout}, 32'h44);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ram_wr", {31'b0, ram_wr}, 32'h0);
    check("rst_mid_ram_a", ram_a, 32'h0);
    check("rst_mid_ram_dout", {24'b0, ram_dout}, 32'h0);
    check("rst_mid_mem_done", {31'b0, mem_done}, 32'h0);
    check("rst_mid_if_data", if_data, 32'h0);
    check("rst_mid_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b1; mem_req = 1'b0; mem_mask = 2'b00;
    w0 = wr_total;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_done) cnt++;
    end
    check("rst_mid_no_done", cnt, 0);
    check("rst_mid_no_wr", wr_total - w0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequencer and arbiter for the single byte-wide RAM/IO bus.
- Shares the bus between two requesters: instruction fetch (IF port, always 4 bytes) and load/store (MEM port, 1/2/4 bytes, read or write).
- Serialises each request into per-byte bus cycles and reassembles read data.
- Sits between the IF/MEM stages and the top-level RAM pins; the instruction cache stays upstream on the IF port.

Parameters:
- ADDR_W, 32, width of all address ports.
- IO_ADDR, 32'h30000, read address treated as a single-byte IO port; the read is never widened.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low: rst==0 at a posedge resets the block
- rdy_in  in  1  system ready; 0 freezes the block
- if_req  in  1  fetch request; held until if_done or if_flush
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  abort the in-flight fetch
- if_done  out  1  one-cycle pulse: if_data valid
- if_data  out  32  fetched instruction, little-endian
- mem_req  in  1  load/store request; held until mem_done
- mem_we  in  1  1=store, 0=load
- mem_mask  in  2  01=byte, 10=half, 11=word; 00 is ignored (no request)
- mem_addr  in  ADDR_W  byte address
- mem_wdata  in  32  store data; byte k is [8k+7:8k]
- mem_done  out  1  one-cycle pulse: load data valid or store complete
- mem_rdata  out  32  load data, zero-extended, unused bytes 0
- ram_a  out  ADDR_W  bus address
- ram_dout  out  8  bus write data
- ram_wr  out  1  bus write strobe
- ram_din  in  8  bus read data; valid one cycle after its address was presented

Behaviour:
- Reset (rst==0 at a posedge, overrides rdy_in):
  - state IDLE; all outputs 0; internal counters 0.
  - Any in-flight op is dropped and no done pulse is issued.
- States:
  - IDLE: accepts a new request.
  - READ: issuing addresses and capturing read bytes.
  - WRITE: issuing store bytes.
  - DONE: one-cycle done pulse, then back to IDLE.
- Arbitration, evaluated only in IDLE:
  - mem_req (mask≠00) wins over if_req.
  - No preemption: a fetch in progress completes before a pending mem_req is accepted, and vice versa.
- Byte count N:
  - IF requests: 4.
  - MEM requests: 1/2/4 from mask.
  - A read with address==IO_ADDR is forced to N=1.
- Read timing (acceptance edge E0):
  - ram_a = A+k is registered at edge Ek, for k=0..N-1.
  - ram_din is captured into byte k at edge E(k+1).
  - done is registered high at edge E(N+1) and stays high for exactly one cycle.
  - Word read: done at E5. Byte read: done at E2.
  - ram_wr stays 0 for the whole read.
- Write timing:
  - At edge Ek (k=0..N-1): ram_a=A+k, ram_dout=wdata byte k, ram_wr=1.
  - At edge EN: ram_wr=0 and mem_done=1 for one cycle.
  - Byte store: done at E1. Word store: done at E4.
- if_data / mem_rdata:
  - Hold their last value when done is low.
  - Only the requester whose port pulses done may consume its data.
- rdy_in==0: all registers hold; ram_wr is forced to 0 combinationally.
- Read replay after a stall: on the first rdy_in==1 edge after a stall during READ:
  - No byte is captured on that edge.
  - ram_a <= A+c, where c = bytes captured so far.
  - Issue restarts from byte c; result bytes are identical to the unstalled case.
  - Writes resume at the held byte with no replay.
- if_flush:
  - During an IF op: return to IDLE at the next edge, with no if_done.
  - A new if_req may be accepted from the following IDLE cycle.
  - No effect on a MEM op, in IDLE, or in the cycle if_done is high.
- Back-to-back: the cycle after DONE is IDLE. The minimum gap between requests is therefore one idle cycle.
- mem_req/if_req inputs are sampled only in IDLE; changes mid-operation are ignored.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE/READ/WRITE/DONE).
  - mask encodings MASK_B/MASK_H/MASK_W.
  - IO_ADDR default.
  - function mask_to_len.
- One sub-module, mem_byte_asm: a 4-byte assembly register with lane-select write, clear, and zero-extended output. Used for read capture.

Test Plan:
- IF word fetch: if_addr=0x100, RAM bytes 13,00,50,00 → if_done exactly 5 cycles after acceptance, if_data=0x00500013, ram_wr never 1.
- Simultaneous requests: if_req and mem_req (load word from 0x1000) asserted in the same cycle → MEM served first; IF served only after the DONE+IDLE cycle; mem_rdata correct.
- Stores:
  - Half store 0xBEEF to 0x20 → ram_wr=1 on two cycles: (0x20,EF), (0x21,BE); mem_done one cycle later.
  - Byte store → mem_done at E1.
- IO read: load word from 0x30000 with din=0x41 → only one address issued, mem_done at E2, mem_rdata=0x00000041.
- Stall replay: rdy_in=0 for 3 cycles after byte1 is captured during a word read → ram_a re-presented at A+2; final data equals the unstalled case; ram_wr stays 0 throughout.
- Flush and reset:
  - if_flush at E2 of a fetch → no if_done; IDLE next cycle.
  - rst=0 mid-store → ram_wr=0 and all outputs 0 after that edge; no mem_done.
